// File: rtl/regfile_pkg.sv
// Shared DLX register-file constants and request types for regfile_sb and sb_pending.
package regfile_pkg;

   localparam int unsigned DLX_XLEN  = 32;
   localparam int unsigned DLX_NREGS = 32;
   localparam int unsigned DLX_NREAD = 3;
   localparam int unsigned DLX_AW    = $clog2(DLX_NREGS);

   typedef struct packed {
      logic                en;
      logic [DLX_AW-1:0]   addr;
      logic [DLX_XLEN-1:0] data;
   } wb_req_t;

   typedef struct packed {
      logic              en;
      logic [DLX_AW-1:0] addr;
   } iss_req_t;

endpackage

// File: rtl/sb_pending.sv
// Hazard scoreboard: one pending bit per register plus an incrementally maintained popcount.
module sb_pending
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = DLX_NREGS,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             iss_en_i,
   input  logic [AW-1:0]    iss_addr_i,
   input  logic             wb_en_i,
   input  logic [AW-1:0]    wb_addr_i,
   input  logic             flush_i,
   output logic [DEPTH-1:0] pending_o,
   output logic [AW:0]      pending_cnt_o
);

   logic [DEPTH-1:0] pending_q, pending_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             set_eff, clr_eff, iss_hit, wb_hit;

   always_comb begin
      iss_hit = iss_en_i && (iss_addr_i != '0);
      wb_hit  = wb_en_i && (wb_addr_i != '0);
      // Count only transitions that actually flip a bit; an issue to the
      // same register wins over the write-back clear.
      set_eff = iss_hit && !pending_q[iss_addr_i];
      clr_eff = wb_hit && pending_q[wb_addr_i] && !(iss_hit && (iss_addr_i == wb_addr_i));

      pending_d = pending_q;
      if (wb_hit) pending_d[wb_addr_i] = 1'b0;
      if (iss_hit) pending_d[iss_addr_i] = 1'b1;
      pending_d[0] = 1'b0;
      cnt_d = cnt_q + (AW+1)'(set_eff) - (AW+1)'(clr_eff);

      if (flush_i) begin
         pending_d = '0;
         cnt_d     = '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pending_q <= '0;
         cnt_q     <= '0;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   assign pending_o     = pending_q;
   assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with hazard scoreboard; REGFILE_SB_BYPASS_EN enables write-through forwarding.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH = DLX_XLEN,
   parameter int unsigned DEPTH = DLX_NREGS,
   parameter int unsigned NREAD = DLX_NREAD,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [NREAD-1:0][AW-1:0]   rs_i,
   output logic [NREAD-1:0][WIDTH-1:0] rd_data_o,
   output logic [NREAD-1:0]           rd_ready_o,
   input  logic                       wb_en_i,
   input  logic [AW-1:0]              wb_addr_i,
   input  logic [WIDTH-1:0]           wb_data_i,
   input  logic                       iss_en_i,
   input  logic [AW-1:0]              iss_addr_i,
   input  logic                       flush_i,
   output logic [AW:0]                pending_cnt_o
);

   logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
   logic [DEPTH-1:0]            pending;

   sb_pending #(
      .DEPTH (DEPTH)
   ) u_sb_pending (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .iss_en_i      (iss_en_i),
      .iss_addr_i    (iss_addr_i),
      .wb_en_i       (wb_en_i),
      .wb_addr_i     (wb_addr_i),
      .flush_i       (flush_i),
      .pending_o     (pending),
      .pending_cnt_o (pending_cnt_o)
   );

   always_comb begin
      regs_d = regs_q;
      if (wb_en_i && (wb_addr_i != '0)) regs_d[wb_addr_i] = wb_data_i;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) regs_q <= '0;
      else         regs_q <= regs_d;
   end

   always_comb begin
      rd_data_o  = '0;
      rd_ready_o = '0;
      for (int i = 0; i < int'(NREAD); i++) begin
         if (rs_i[i] == '0) begin
            rd_data_o[i]  = '0;
            rd_ready_o[i] = 1'b1;
`ifdef REGFILE_SB_BYPASS_EN
         // Forwarding is gated during reset so reads see the cleared state.
         end else if (!reset_i && wb_en_i && (wb_addr_i == rs_i[i])) begin
            rd_data_o[i]  = wb_data_i;
            rd_ready_o[i] = 1'b1;
`endif
         end else begin
            rd_data_o[i]  = regs_q[rs_i[i]];
            rd_ready_o[i] = !pending[rs_i[i]];
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow REGFILE_SB_BYPASS_EN.
module tb_regfile_sb;
   import regfile_pkg::*;

`ifdef REGFILE_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                          clk = 1'b0;
   logic                          reset;
   logic [DLX_NREAD-1:0][DLX_AW-1:0]   rs;
   logic [DLX_NREAD-1:0][DLX_XLEN-1:0] rd_data;
   logic [DLX_NREAD-1:0]          rd_ready;
   wb_req_t                       wb;
   iss_req_t                      iss;
   logic                          flush;
   logic [DLX_AW:0]               cnt;

   int n_checks = 0;
   int n_err    = 0;

   regfile_sb dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .rs_i          (rs),
      .rd_data_o     (rd_data),
      .rd_ready_o    (rd_ready),
      .wb_en_i       (wb.en),
      .wb_addr_i     (wb.addr),
      .wb_data_i     (wb.data),
      .iss_en_i      (iss.en),
      .iss_addr_i    (iss.addr),
      .flush_i       (flush),
      .pending_cnt_o (cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb    = '0;
      iss   = '0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      wb = '{en: 1'b1, addr: 5'd5, data: 32'hAAAA_5555};
      iss = '{en: 1'b1, addr: 5'd5};
      tick();
      for (int r = 0; r < 32; r++) begin
         rs = {DLX_AW'(r), DLX_AW'(r), DLX_AW'(r)};
         #1;
         for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (rd_data[p] !== '0 || rd_ready[p] !== 1'b1) begin
               n_err++;
               $display("FAIL reset_read reg=%0d port=%0d got data=%h ready=%b want 0/1",
                        r, p, rd_data[p], rd_ready[p]);
            end
         end
      end
      n_checks++;
      if (cnt !== '0) begin
         n_err++;
         $display("FAIL reset_cnt got %0d want 0", cnt);
      end
      idle();
      reset = 1'b0;
      tick();
      rs = {5'd0, 5'd0, 5'd5};
      #1;
      n_checks++;
      if (rd_data[0] !== '0 || rd_ready[0] !== 1'b1) begin
         n_err++;
         $display("FAIL reset_wb_ignored got %h/%b want 0/1", rd_data[0], rd_ready[0]);
      end
   endtask

   task automatic test_write_bypass();
      wb = '{en: 1'b1, addr: 5'd5, data: 32'hDEAD_BEEF};
      rs[0] = 5'd5;
      #1;
      n_checks++;
      if (rd_data[0] !== (BYP ? 32'hDEAD_BEEF : 32'h0) || rd_ready[0] !== 1'b1) begin
         n_err++;
         $display("FAIL wb_same_cycle got %h/%b want %h/1", rd_data[0], rd_ready[0],
                  BYP ? 32'hDEAD_BEEF : 32'h0);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (rd_data[0] !== 32'hDEAD_BEEF || rd_ready[0] !== 1'b1) begin
         n_err++;
         $display("FAIL wb_next_cycle got %h/%b want deadbeef/1", rd_data[0], rd_ready[0]);
      end
   endtask

   task automatic test_issue_wb();
      iss = '{en: 1'b1, addr: 5'd7};
      rs[1] = 5'd7;
      #1;
      n_checks++;
      if (rd_ready[1] !== 1'b1) begin
         n_err++;
         $display("FAIL iss_same_cycle_ready got %b want 1", rd_ready[1]);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (rd_ready[1] !== 1'b0 || cnt !== 6'd1) begin
         n_err++;
         $display("FAIL iss_next_cycle got ready=%b cnt=%0d want 0/1", rd_ready[1], cnt);
      end
      wb = '{en: 1'b1, addr: 5'd7, data: 32'h12};
      #1;
      n_checks++;
      if (rd_ready[1] !== BYP || rd_data[1] !== (BYP ? 32'h12 : 32'h0) || cnt !== 6'd1) begin
         n_err++;
         $display("FAIL wb7_same_cycle got %h/%b cnt=%0d want %h/%b cnt=1",
                  rd_data[1], rd_ready[1], cnt, BYP ? 32'h12 : 32'h0, BYP);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (rd_ready[1] !== 1'b1 || rd_data[1] !== 32'h12 || cnt !== 6'd0) begin
         n_err++;
         $display("FAIL wb7_next_cycle got %h/%b cnt=%0d want 12/1 cnt=0",
                  rd_data[1], rd_ready[1], cnt);
      end
   endtask

   task automatic test_set_clear_same();
      iss = '{en: 1'b1, addr: 5'd9};
      tick();
      iss = '{en: 1'b1, addr: 5'd9};
      wb  = '{en: 1'b1, addr: 5'd9, data: 32'h99};
      tick();
      idle();
      rs[2] = 5'd9;
      #1;
      n_checks++;
      if (rd_data[2] !== 32'h99 || rd_ready[2] !== 1'b0 || cnt !== 6'd1) begin
         n_err++;
         $display("FAIL set_clear_same got %h/%b cnt=%0d want 99/0 cnt=1",
                  rd_data[2], rd_ready[2], cnt);
      end
      // Different registers: issue 11 while retiring 9, count must hold.
      iss = '{en: 1'b1, addr: 5'd11};
      wb  = '{en: 1'b1, addr: 5'd9, data: 32'h98};
      tick();
      idle();
      rs[0] = 5'd11;
      #1;
      n_checks++;
      if (rd_ready[2] !== 1'b1 || rd_ready[0] !== 1'b0 || cnt !== 6'd1) begin
         n_err++;
         $display("FAIL set_clear_diff got r9=%b r11=%b cnt=%0d want 1/0 cnt=1",
                  rd_ready[2], rd_ready[0], cnt);
      end
      wb = '{en: 1'b1, addr: 5'd11, data: 32'h0};
      tick();
      idle();
      #1;
      n_checks++;
      if (cnt !== 6'd0) begin
         n_err++;
         $display("FAIL retire11_cnt got %0d want 0", cnt);
      end
   endtask

   task automatic test_reg0();
      iss = '{en: 1'b1, addr: 5'd0};
      wb  = '{en: 1'b1, addr: 5'd0, data: 32'hFF};
      rs[2] = 5'd0;
      #1;
      n_checks++;
      if (rd_data[2] !== '0 || rd_ready[2] !== 1'b1) begin
         n_err++;
         $display("FAIL reg0_same_cycle got %h/%b want 0/1", rd_data[2], rd_ready[2]);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (rd_data[2] !== '0 || rd_ready[2] !== 1'b1 || cnt !== 6'd0) begin
         n_err++;
         $display("FAIL reg0_next_cycle got %h/%b cnt=%0d want 0/1 cnt=0",
                  rd_data[2], rd_ready[2], cnt);
      end
   endtask

   task automatic test_flush_reset();
      for (int r = 1; r <= 3; r++) begin
         iss = '{en: 1'b1, addr: DLX_AW'(r)};
         tick();
      end
      idle();
      #1;
      n_checks++;
      if (cnt !== 6'd3) begin
         n_err++;
         $display("FAIL issue3_cnt got %0d want 3", cnt);
      end
      flush = 1'b1;
      iss = '{en: 1'b1, addr: 5'd4};
      tick();
      idle();
      rs = {5'd2, 5'd1, 5'd4};
      #1;
      n_checks++;
      if (rd_ready !== 3'b111 || cnt !== 6'd0) begin
         n_err++;
         $display("FAIL flush got ready=%b cnt=%0d want 111 cnt=0", rd_ready, cnt);
      end
      iss = '{en: 1'b1, addr: 5'd1};
      tick();
      iss = '{en: 1'b1, addr: 5'd2};
      wb  = '{en: 1'b1, addr: 5'd3, data: 32'h33};
      tick();
      idle();
      rs = {5'd3, 5'd1, 5'd2};
      #1;
      n_checks++;
      if (rd_data[2] !== 32'h33 || rd_ready !== 3'b100 || cnt !== 6'd2) begin
         n_err++;
         $display("FAIL pre_reset got r3=%h ready=%b cnt=%0d want 33 100 cnt=2",
                  rd_data[2], rd_ready, cnt);
      end
      #1;
      reset = 1'b1;
      #1;
      n_checks++;
      if (rd_data[2] !== '0 || rd_ready !== 3'b111 || cnt !== 6'd0) begin
         n_err++;
         $display("FAIL async_reset got r3=%h ready=%b cnt=%0d want 0 111 cnt=0",
                  rd_data[2], rd_ready, cnt);
      end
      tick();
      reset = 1'b0;
      wb  = '{en: 1'b1, addr: 5'd6, data: 32'h66};
      iss = '{en: 1'b1, addr: 5'd8};
      tick();
      idle();
      rs = {5'd8, 5'd0, 5'd6};
      #1;
      n_checks++;
      if (rd_data[0] !== 32'h66 || rd_ready[2] !== 1'b0 || cnt !== 6'd1) begin
         n_err++;
         $display("FAIL post_reset got r6=%h r8rdy=%b cnt=%0d want 66 0 cnt=1",
                  rd_data[0], rd_ready[2], cnt);
      end
   endtask

   initial begin
      rs = '0;
      test_reset();
      test_write_bypass();
      test_issue_wb();
      test_set_clear_same();
      test_reg0();
      test_flush_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
